// File: rtl/mem1_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem1_stage
// Brief   : First memory stage: alignment check, strobes, D-cache request.
// Rev     : 1.0  initial release
// ============================================================================
module mem1_stage #(
  parameter logic [5:0] ALE_ECODE = 6'h9,
  parameter int         ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              is_stall,
  input  logic              is_flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_ex_out,
  input  logic [ADDR_W-1:0] in_pc_plus4,
  input  logic [ADDR_W-1:0] in_rkd_data,
  input  logic [4:0]        in_rd,
  input  logic              in_is_wr_rd,
  input  logic              in_is_wr_rd_pc_plus4,
  input  logic              in_is_mem,
  input  logic              in_is_store,
  input  logic              in_is_signed,
  input  logic [1:0]        in_byte_type,
  input  logic              in_excp_valid,
  input  logic [5:0]        in_excp_code,
  input  logic              dc_req_ready,
  output logic              dc_req_valid,
  output logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_we,
  output logic [3:0]        dc_req_wstrb,
  output logic [ADDR_W-1:0] dc_req_wdata,
  output logic              mem1_stall,
  output logic              fwd_valid,
  output logic [4:0]        fwd_idx,
  output logic [ADDR_W-1:0] fwd_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_wb_data,
  output logic [4:0]        out_rd,
  output logic              out_is_wr_rd,
  output logic              out_is_load,
  output logic [1:0]        out_byte_off,
  output logic [1:0]        out_byte_type,
  output logic              out_is_signed,
  output logic              out_excp_valid,
  output logic [5:0]        out_excp_code,
  output logic [ADDR_W-1:0] out_badv
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SENT = 2'd2;

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ex_out;
  logic [ADDR_W-1:0] r_pc_plus4;
  logic [ADDR_W-1:0] r_rkd;
  logic [4:0]        r_rd;
  logic              r_is_wr_rd;
  logic              r_is_wr_rd_pc4;
  logic              r_is_mem;
  logic              r_is_store;
  logic              r_is_signed;
  logic [1:0]        r_byte_type;
  logic              r_excp_valid;
  logic [5:0]        r_excp_code;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_kill;
  logic              w_kill_nxt;

  logic [1:0]        w_off;
  logic              w_is_byte;
  logic              w_is_half;
  logic              w_is_word;
  logic              w_misalign;
  logic              w_excp;
  logic              w_need_req;
  logic              w_is_load;
  logic [ADDR_W-1:0] w_wb_sel;
  logic              w_req_valid;
  logic              w_stall;
  logic [3:0]        w_wstrb;
  logic [ADDR_W-1:0] w_wdata;

  // A flush also drops a held instruction, so a stalled stage never re-requests it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (is_flush) begin
      r_valid <= 1'b0;
    end else if (!is_stall) begin
      r_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!is_stall) begin
      r_pc           <= in_pc;
      r_ex_out       <= in_ex_out;
      r_pc_plus4     <= in_pc_plus4;
      r_rkd          <= in_rkd_data;
      r_rd           <= in_rd;
      r_is_wr_rd     <= in_is_wr_rd;
      r_is_wr_rd_pc4 <= in_is_wr_rd_pc_plus4;
      r_is_mem       <= in_is_mem;
      r_is_store     <= in_is_store;
      r_is_signed    <= in_is_signed;
      r_byte_type    <= in_byte_type;
      r_excp_valid   <= in_excp_valid;
      r_excp_code    <= in_excp_code;
    end
  end

  assign w_off      = r_ex_out[1:0];
  assign w_is_byte  = (r_byte_type == 2'd0);
  assign w_is_half  = (r_byte_type == 2'd1);
  assign w_is_word  = r_byte_type[1];
  assign w_misalign = r_is_mem & ((w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00)));
  assign w_excp     = r_valid & (r_excp_valid | w_misalign);
  assign w_need_req = r_valid & r_is_mem & ~w_excp;
  assign w_is_load  = r_is_mem & ~r_is_store;
  assign w_wb_sel   = r_is_wr_rd_pc4 ? r_pc_plus4 : r_ex_out;

  always_comb begin
    w_wstrb = 4'hF;
    w_wdata = r_rkd;
    if (w_is_byte) begin
      w_wstrb = 4'b0001 << w_off;
      w_wdata = {4{r_rkd[7:0]}};
    end else if (w_is_half) begin
      w_wstrb = 4'b0011 << w_off;
      w_wdata = {2{r_rkd[15:0]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  // SENT is only visited while the accepted instruction is still held by ctrl.
  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    case (r_state)
      S_IDLE: begin
        if (w_req_valid) begin
          if (dc_req_ready) begin
            w_state_nxt = is_stall ? S_SENT : S_IDLE;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dc_req_ready) begin
          w_kill_nxt  = 1'b0;
          w_state_nxt = (r_kill | is_flush | ~is_stall) ? S_IDLE : S_SENT;
        end else if (is_flush) begin
          w_kill_nxt  = 1'b1;
        end
      end
      S_SENT: begin
        if (is_flush || !is_stall) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_kill_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_req_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_req_valid = w_need_req & ~is_flush;
      S_WAIT:  w_req_valid = 1'b1;
      default: w_req_valid = 1'b0;
    endcase
    w_stall = (w_need_req & (r_state != S_SENT) & ~(w_req_valid & dc_req_ready))
            | ((r_state == S_WAIT) & r_kill);
  end

  assign dc_req_valid   = w_req_valid;
  assign dc_req_addr    = r_ex_out;
  assign dc_req_we      = r_is_store;
  assign dc_req_wstrb   = w_wstrb;
  assign dc_req_wdata   = w_wdata;
  assign mem1_stall     = w_stall;

  assign fwd_valid      = r_valid & ~is_flush & r_is_wr_rd & ~w_is_load & (r_rd != 5'd0);
  assign fwd_idx        = r_rd;
  assign fwd_data       = w_wb_sel;

  assign out_valid      = r_valid & ~is_flush & ~w_stall;
  assign out_pc         = r_pc;
  assign out_wb_data    = w_wb_sel;
  assign out_rd         = r_rd;
  assign out_is_wr_rd   = r_is_wr_rd;
  assign out_is_load    = w_is_load;
  assign out_byte_off   = w_off;
  assign out_byte_type  = r_byte_type;
  assign out_is_signed  = r_is_signed;
  assign out_excp_valid = w_excp;
  assign out_excp_code  = r_excp_valid ? r_excp_code : ALE_ECODE;
  assign out_badv       = r_ex_out;

endmodule
`default_nettype wire
